fm_mult_scheduler: RTL and testbench
====================================

# fm_mult_scheduler

Sequencer that time-shares one signed sequential multiplier across the three products of the FM stereo modulator: the 19 kHz pilot times Kp, LI_RIGHT times the 38 kHz subcarrier, and the composite sum times Kf. It is triggered once per 192 kHz sample by `clken_192` and produces `FMout` with a one-cycle `ready_block_192` strobe. It sits between the DDS/interpolator outputs and a single `seqmultNM` instance (M=20, N=9), replacing three dedicated multipliers.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent waiting for `mul_ready` per product before aborting.
- `clock` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `clken_192` input 1: one-cycle sample strobe that starts a frame.
- `LI_LEFT` input 18: signed mono (L+R) sample.
- `LI_RIGHT` input 18: signed difference (L−R) sample.
- `sine_19` input 8: signed 19 kHz pilot sample.
- `sine_38` input 8: signed 38 kHz subcarrier sample.
- `Kp` input 4: unsigned pilot gain.
- `Kf` input 8: unsigned FM deviation gain.
- `mul_start` output 1: start pulse to the shared multiplier.
- `mul_a` output 20: signed operand A (sign-extended).
- `mul_b` output 9: signed operand B (sign-extended, or zero-extended for gains).
- `mul_ready` input 1: multiplier result valid.
- `mul_r` input 29: signed multiplier product.
- `FMout` output 24: signed modulator output register.
- `ready_block_192` output 1: one-cycle pulse when `FMout` updates.
- `busy` output 1: high while a frame is in progress.
- `overrun` output 1: sticky; a `clken_192` arrived while busy.
- `timeout_err` output 1: sticky; a multiplier wait exceeded `TIMEOUT`.

## Operation
- **States:** IDLE, PIL_ST, PIL_WT, SUB_ST, SUB_WT, SUM, FM_ST, FM_WT, DONE.
- **IDLE + `clken_192`=1:** latch all data and gain inputs into shadow registers, set busy=1, go to PIL_ST.
- **Start states (`*_ST`):** `mul_start`=1 for exactly this one cycle (Moore decode). The next state is the matching `*_WT`.
- **Operands:**
  - Pilot: A=sext(sine_19), B={0,Kp}.
  - Sub: A=sext(LI_RIGHT), B=sext(sine_38).
  - FM: A=sum, B={0,Kf}.
  - Operands are driven from ST through the end of WT and are 0 in IDLE.
- **Wait states (`*_WT`):** `mul_ready` is ignored on the first WT cycle. On the first later cycle with `mul_ready`=1, capture `mul_r` and advance: PIL_WT→SUB_ST, SUB_WT→SUM, FM_WT→DONE.
- **Timeout:** a wait counter starts at 0 on WT entry. When it reaches `TIMEOUT` without a capture, set timeout_err=1, go to IDLE, clear busy. `FMout` is unchanged and no ready pulse is issued.
- **Arithmetic:**
  - pilot_s = pilot[12:0] <<< 5, as 18-bit signed.
  - sub_s = sub[25:0] >>> 7 (arithmetic shift), kept in 19 bits.
  - SUM state: sum = LI_LEFT + pilot_s + sub_s, 20-bit signed. Worst-case |sum| < 2^19, so no saturation is needed.
  - DONE state: FMout = fm[28:5] (arithmetic >>> 5). ready_block_192=1 for this cycle only. busy=0 from the next cycle; state returns to IDLE.
- **`clken_192` while busy:** set overrun=1 and ignore the strobe. The current frame completes normally.
- **Same-cycle DONE and `clken_192`:** counts as overrun. The next frame waits for the next strobe.

## Timing
- **Reset values:** FMout=0, ready_block_192=0, busy=0, overrun=0, timeout_err=0, mul_start=0, mul_a=0, mul_b=0, state=IDLE, wait counter=0.
- **Reset mid-frame:** all outputs return to the reset values on the next edge. No partial result is written.
- **Frame latency:** with a multiplier that raises ready R cycles after the start cycle (R≥2), a frame occupies 1 (latch) + 3·(1+R) + 1 (SUM) + 1 (DONE) cycles. ready_block_192 is asserted in the last of these cycles.
- **Minimum strobe spacing:** 192 kHz frames must satisfy 3R+6 ≤ the clock/192k ratio.

## Configuration
- **`FM_PILOT_EN` defined:** the pilot product is computed as described above.
- **`FM_PILOT_EN` undefined:**
  - PIL_ST and PIL_WT are removed; IDLE goes directly to SUB_ST.
  - pilot_s=0 and Kp/sine_19 are unused.
  - Frame latency drops by 1+R cycles.

## Test plan
- **Mono path:** LI_LEFT=1000, LI_RIGHT=0, sine_19=0, sine_38=0, Kp=0, Kf=32, one strobe → FMout=1000, single ready pulse, exactly 3 mul_start pulses.
- **Pilot:** sine_19=100, Kp=4, Kf=32, others 0 → pilot_s=12800, FMout=12800. With `FM_PILOT_EN` undefined → FMout=0 and 2 start pulses.
- **Subcarrier, signed:** LI_RIGHT=1280, sine_38=−100, Kf=32, others 0 → sub_s=−1000, FMout=−1000 (0xFFFC18).
- **Overrun:** second `clken_192` issued 5 cycles after the first → overrun=1, the first frame's FMout is correct, only one ready pulse.
- **Timeout:** model holds mul_ready=0, TIMEOUT=64 → timeout_err=1 after 64 cycles in PIL_WT, busy=0, FMout keeps its prior value, no ready pulse.
- **Reset mid-frame:** reset asserted during SUB_WT → next edge: state IDLE, all outputs 0. A subsequent strobe produces a correct frame.

Source files
------------

// File: rtl/fm_mult_scheduler.sv
// Time-shares one signed sequential multiplier across the pilot, subcarrier and FM-gain
// products of the stereo modulator. Define FM_PILOT_EN to include the 19 kHz pilot product.
module fm_mult_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clken_192,
  input  logic [17:0] LI_LEFT,
  input  logic [17:0] LI_RIGHT,
  input  logic [7:0]  sine_19,
  input  logic [7:0]  sine_38,
  input  logic [3:0]  Kp,
  input  logic [7:0]  Kf,
  output logic        mul_start,
  output logic [19:0] mul_a,
  output logic [8:0]  mul_b,
  input  logic        mul_ready,
  input  logic [28:0] mul_r,
  output logic [23:0] FMout,
  output logic        ready_block_192,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    PIL_ST = 4'd1,
    PIL_WT = 4'd2,
    SUB_ST = 4'd3,
    SUB_WT = 4'd4,
    SUM    = 4'd5,
    FM_ST  = 4'd6,
    FM_WT  = 4'd7,
    DONE   = 4'd8
  } state_t;

`ifdef FM_PILOT_EN
  localparam state_t FIRST_ST = PIL_ST;
`else
  localparam state_t FIRST_ST = SUB_ST;
`endif

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_r;
  state_t          next_state_s;
  logic [CW-1:0]   wait_cnt_r;
  logic [17:0]     left_r;
  logic [17:0]     right_r;
  logic [7:0]      s38_r;
  logic [7:0]      kf_r;
  logic [17:0]     pilot_s_r;
  logic [18:0]     sub_s_r;
  logic [19:0]     sum_s;
  logic [19:0]     op_a_s;
  logic [8:0]      op_b_s;
  logic            in_wt_s;
  logic            got_s;
  logic            tmo_s;
  logic [17:0]     sub_src_a_s;
  logic [7:0]      sub_src_b_s;

  assign in_wt_s = (state_r == PIL_WT) || (state_r == SUB_WT) || (state_r == FM_WT);
  // The first wait cycle never captures: the multiplier cannot have finished yet.
  assign got_s   = in_wt_s && (wait_cnt_r != '0) && mul_ready;
  assign tmo_s   = in_wt_s && !got_s && (wait_cnt_r == CW'(TIMEOUT - 1));

  assign sum_s = {{2{left_r[17]}}, left_r}
               + {{2{pilot_s_r[17]}}, pilot_s_r}
               + {sub_s_r[18], sub_s_r};

  // Entering SUB_ST straight from IDLE means the shadow registers are not loaded yet.
  assign sub_src_a_s = (state_r == IDLE) ? LI_RIGHT : right_r;
  assign sub_src_b_s = (state_r == IDLE) ? sine_38  : s38_r;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (clken_192) next_state_s = FIRST_ST; else next_state_s = IDLE;
      PIL_ST:  next_state_s = PIL_WT;
      PIL_WT:  if (got_s) next_state_s = SUB_ST; else if (tmo_s) next_state_s = IDLE; else next_state_s = PIL_WT;
      SUB_ST:  next_state_s = SUB_WT;
      SUB_WT:  if (got_s) next_state_s = SUM; else if (tmo_s) next_state_s = IDLE; else next_state_s = SUB_WT;
      SUM:     next_state_s = FM_ST;
      FM_ST:   next_state_s = FM_WT;
      FM_WT:   if (got_s) next_state_s = DONE; else if (tmo_s) next_state_s = IDLE; else next_state_s = FM_WT;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand selection: loaded on entry to a start state, held through its wait state.
  always_comb begin
    op_a_s = 20'd0;
    op_b_s = 9'd0;
    case (next_state_s)
      PIL_ST: begin
        op_a_s = {{12{sine_19[7]}}, sine_19};
        op_b_s = {5'd0, Kp};
      end
      SUB_ST: begin
        op_a_s = {{2{sub_src_a_s[17]}}, sub_src_a_s};
        op_b_s = {sub_src_b_s[7], sub_src_b_s};
      end
      FM_ST: begin
        op_a_s = sum_s;
        op_b_s = {1'b0, kf_r};
      end
      PIL_WT, SUB_WT, FM_WT: begin
        op_a_s = mul_a;
        op_b_s = mul_b;
      end
      default: begin
        op_a_s = 20'd0;
        op_b_s = 9'd0;
      end
    endcase
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r      <= '0;
      left_r          <= 18'd0;
      right_r         <= 18'd0;
      s38_r           <= 8'd0;
      kf_r            <= 8'd0;
      pilot_s_r       <= 18'd0;
      sub_s_r         <= 19'd0;
      mul_start       <= 1'b0;
      mul_a           <= 20'd0;
      mul_b           <= 9'd0;
      FMout           <= 24'd0;
      ready_block_192 <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      mul_start <= (next_state_s == PIL_ST) || (next_state_s == SUB_ST) || (next_state_s == FM_ST);
      mul_a     <= op_a_s;
      mul_b     <= op_b_s;
      busy      <= (next_state_s != IDLE);
      if (in_wt_s && (next_state_s == state_r)) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      if ((state_r == IDLE) && clken_192) begin
        left_r  <= LI_LEFT;
        right_r <= LI_RIGHT;
        s38_r   <= sine_38;
        kf_r    <= Kf;
      end
      if (clken_192 && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end
      if (tmo_s) begin
        timeout_err <= 1'b1;
      end
      if (got_s && (state_r == PIL_WT)) begin
        pilot_s_r <= {mul_r[12:0], 5'd0};
      end
      if (got_s && (state_r == SUB_WT)) begin
        sub_s_r <= mul_r[25:7];
      end
      if (got_s && (state_r == FM_WT)) begin
        FMout <= mul_r[28:5];
      end
      ready_block_192 <= got_s && (state_r == FM_WT);
    end
  end

endmodule

// File: tb/tb_fm_mult_scheduler.sv
// Directed self-checking bench for fm_mult_scheduler with a behavioural sequential
// multiplier that raises ready R cycles after each start pulse.
module tb_fm_mult_scheduler;

  localparam int R = 3;
`ifdef FM_PILOT_EN
  localparam int NST   = 3;
  localparam int LAT   = 3 * R + 6;
  localparam int SUBWT = 7;
`else
  localparam int NST   = 2;
  localparam int LAT   = 2 * R + 5;
  localparam int SUBWT = 3;
`endif

  logic        clock;
  logic        reset;
  logic        clken_192;
  logic [17:0] LI_LEFT;
  logic [17:0] LI_RIGHT;
  logic [7:0]  sine_19;
  logic [7:0]  sine_38;
  logic [3:0]  Kp;
  logic [7:0]  Kf;
  logic        mul_start;
  logic [19:0] mul_a;
  logic [8:0]  mul_b;
  logic        mul_ready;
  logic [28:0] mul_r;
  logic [23:0] FMout;
  logic        ready_block_192;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  fm_mult_scheduler #(.TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .clken_192(clken_192),
    .LI_LEFT(LI_LEFT), .LI_RIGHT(LI_RIGHT), .sine_19(sine_19), .sine_38(sine_38),
    .Kp(Kp), .Kf(Kf), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_r(mul_r), .FMout(FMout),
    .ready_block_192(ready_block_192), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural multiplier model.
  logic [3:0]         dly;
  logic [19:0]        ma;
  logic [8:0]         mb;
  logic signed [28:0] pa;
  logic signed [28:0] pb;
  logic               hold_off;

  always @(posedge clock) begin
    if (reset) begin
      dly <= 4'd0;
      ma  <= 20'd0;
      mb  <= 9'd0;
    end else if (mul_start) begin
      dly <= 4'(R);
      ma  <= mul_a;
      mb  <= mul_b;
    end else if (dly != 4'd0) begin
      dly <= dly - 4'd1;
    end
  end

  assign pa        = $signed(ma);
  assign pb        = $signed(mb);
  assign mul_r     = pa * pb;
  assign mul_ready = !hold_off && (dly == 4'd1);

  // Event counters.
  int cyc = 0;
  int ready_cnt = 0;
  int start_cnt = 0;
  int ready_cyc = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ready_block_192) begin
      ready_cnt <= ready_cnt + 1;
      ready_cyc <= cyc + 1;
    end
    if (mul_start) start_cnt <= start_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int c0, r0, s0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [17:0] l, input logic [17:0] r, input logic [7:0] s19,
                        input logic [7:0] s38, input logic [3:0] kp, input logic [7:0] kf);
    LI_LEFT = l; LI_RIGHT = r; sine_19 = s19; sine_38 = s38; Kp = kp; Kf = kf;
  endtask

  task automatic strobe;
    clken_192 = 1'b1;
    c0 = cyc; r0 = ready_cnt; s0 = start_cnt;
    tick();
    clken_192 = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check_value({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic frame(input string tag, input logic [23:0] exp_fm);
    strobe();
    wait_idle(tag);
    check_value({tag, "_fm"}, {8'd0, FMout}, {8'd0, exp_fm});
    check_value({tag, "_ready"}, 32'(ready_cnt - r0), 32'd1);
    check_value({tag, "_starts"}, 32'(start_cnt - s0), 32'(NST));
    check_value({tag, "_latency"}, 32'(ready_cyc - c0), 32'(LAT));
  endtask

  initial begin
    reset = 1'b1; clken_192 = 1'b0; hold_off = 1'b0;
    set_in(18'd0, 18'd0, 8'd0, 8'd0, 4'd0, 8'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_value("rst_fmout", {8'd0, FMout}, 32'd0);
    check_value("rst_ready", {31'd0, ready_block_192}, 32'd0);
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_overrun", {31'd0, overrun}, 32'd0);
    check_value("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check_value("rst_start", {31'd0, mul_start}, 32'd0);
    check_value("rst_mul_a", {12'd0, mul_a}, 32'd0);
    check_value("rst_mul_b", {23'd0, mul_b}, 32'd0);

    set_in(18'd1000, 18'd0, 8'd0, 8'd0, 4'd0, 8'd32);
    frame("mono", 24'd1000);

    set_in(18'd0, 18'd0, 8'd100, 8'd0, 4'd4, 8'd32);
`ifdef FM_PILOT_EN
    frame("pilot", 24'd12800);
`else
    frame("pilot", 24'd0);
`endif

    set_in(18'd0, 18'd1280, 8'd0, 8'h9C, 4'd0, 8'd32);
    frame("sub", 24'hFFFC18);

    set_in(-18'sd2000, 18'd256, -8'sd10, 8'd50, 4'd15, 8'd64);
`ifdef FM_PILOT_EN
    frame("mix", 24'hFFCBA8);
`else
    frame("mix", 24'hFFF128);
`endif

    set_in(-18'sd1, 18'd0, 8'd0, 8'd0, 4'd0, 8'd1);
    frame("floor", 24'hFFFFFF);

    set_in(18'd131071, 18'd0, 8'd0, 8'd0, 4'd0, 8'd255);
    frame("max", 24'd1044472);

    // Second strobe five cycles after the first.
    set_in(18'd777, 18'd0, 8'd0, 8'd0, 4'd0, 8'd32);
    strobe();
    repeat (4) tick();
    check_value("ovr_before", {31'd0, overrun}, 32'd0);
    clken_192 = 1'b1;
    tick();
    clken_192 = 1'b0;
    wait_idle("ovr");
    check_value("ovr_flag", {31'd0, overrun}, 32'd1);
    check_value("ovr_fm", {8'd0, FMout}, 32'd777);
    repeat (20) tick();
    check_value("ovr_ready", 32'(ready_cnt - r0), 32'd1);
    check_value("ovr_busy", {31'd0, busy}, 32'd0);

    // Multiplier never answers.
    hold_off = 1'b1;
    strobe();
    repeat (64) tick();
    check_value("tmo_early", {31'd0, timeout_err}, 32'd0);
    check_value("tmo_busy_early", {31'd0, busy}, 32'd1);
    tick();
    check_value("tmo_flag", {31'd0, timeout_err}, 32'd1);
    check_value("tmo_busy", {31'd0, busy}, 32'd0);
    check_value("tmo_fm", {8'd0, FMout}, 32'd777);
    check_value("tmo_ready", 32'(ready_cnt - r0), 32'd0);
    hold_off = 1'b0;
    repeat (5) tick();

    // Reset during the subcarrier wait.
    set_in(18'd0, 18'd1280, 8'd0, 8'h9C, 4'd0, 8'd32);
    strobe();
    repeat (SUBWT - 1) tick();
    check_value("mid_mul_a", {12'd0, mul_a}, 32'd1280);
    check_value("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check_value("mid_rst_fm", {8'd0, FMout}, 32'd0);
    check_value("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_value("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    check_value("mid_rst_tmo", {31'd0, timeout_err}, 32'd0);
    check_value("mid_rst_mul_a", {12'd0, mul_a}, 32'd0);
    check_value("mid_rst_mul_b", {23'd0, mul_b}, 32'd0);
    check_value("mid_rst_start", {31'd0, mul_start}, 32'd0);
    check_value("mid_rst_ready", {31'd0, ready_block_192}, 32'd0);
    reset = 1'b0;
    tick();
    frame("post_rst", 24'hFFFC18);

    // Strobe landing exactly on the DONE cycle.
    set_in(18'd500, 18'd0, 8'd0, 8'd0, 4'd0, 8'd32);
    strobe();
    repeat (LAT - 2) tick();
    check_value("done_cycle_ready", {31'd0, ready_block_192}, 32'd1);
    clken_192 = 1'b1;
    tick();
    clken_192 = 1'b0;
    wait_idle("done_col");
    check_value("done_col_ovr", {31'd0, overrun}, 32'd1);
    check_value("done_col_fm", {8'd0, FMout}, 32'd500);
    repeat (30) tick();
    check_value("done_col_ready", 32'(ready_cnt - r0), 32'd1);
    check_value("done_col_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
